dmem_store_buffer: RTL and testbench

Posted-write store buffer between the core's memory stage and the data memory. Word stores from the memory stage are accepted in a single cycle into a FIFO and drained to a slow write port under a ready handshake. Loads receive the youngest buffered data for a matching word address, otherwise the memory's asynchronous read data. `ReadDataM` and `full` feed back into the core; `full` is intended for the hazard unit's stall logic.

---
 rtl/stbuf_pkg.sv | 16 +
 rtl/stbuf_match.sv | 33 +++
 rtl/dmem_store_buffer.sv | 123 ++++++++++++
 tb/tb_dmem_store_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/stbuf_pkg.sv
// Shared types and helpers for the dmem store buffer.
// Optional in-place coalescing is enabled by defining STBUF_COALESCE_EN.
package stbuf_pkg;

  localparam int STBUF_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } stbuf_entry_t;

  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/stbuf_match.sv
// Combinational youngest-match selector over the circular store buffer.
// Searches from the oldest slot toward tail, so the youngest match is the last write.
module stbuf_match
  import stbuf_pkg::*;
#(
  parameter  int DEPTH = STBUF_DEPTH_DEFAULT,
  localparam int PtrW  = ptrWidth(DEPTH)
) (
  input  stbuf_entry_t      entries [DEPTH],
  input  logic [DEPTH-1:0]  validMask,
  input  logic [PtrW-1:0]   tail,
  input  logic [29:0]       lookupAddr,
  output logic              hit,
  output logic [31:0]       hit_data
);

  logic [PtrW-1:0] idx;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail - PtrW'(k);
      if (validMask[idx] && (entries[idx].addr == lookupAddr)) begin
        hit      = 1'b1;
        hit_data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer between the memory stage and a slow data memory write port.
// Define STBUF_COALESCE_EN to merge a store into a matching tail-most entry in place.
module dmem_store_buffer
  import stbuf_pkg::*;
#(
  parameter int DEPTH = STBUF_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWriteM,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            WriteDataM,
  output logic [31:0]            ReadDataM,
  output logic [31:0]            mem_raddr,
  input  logic [31:0]            mem_rdata,
  output logic                   mem_we,
  output logic [31:0]            mem_waddr,
  output logic [31:0]            mem_wdata,
  input  logic                   mem_wready,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PtrW = ptrWidth(DEPTH);
  localparam int CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  stbuf_entry_t     entries [DEPTH];
  logic [PtrW-1:0]  head, tail, tailLast;
  logic [DEPTH-1:0] validMask;
  logic [29:0]      wordAddr;
  logic             push, pop, drop, coalesce;
  logic             fwdHit;
  logic [31:0]      fwdData;

  assign wordAddr  = ALUResultM[31:2];
  assign tailLast  = tail - PtrW'(1);
  assign full      = (count == DepthCnt);
  assign empty     = (count == '0);
  assign mem_we    = !empty;
  assign pop       = mem_we && mem_wready;
  assign mem_raddr = ALUResultM;
  assign mem_waddr = {entries[head].addr, 2'b00};
  assign mem_wdata = entries[head].data;

  // An entry stays valid while it is being popped, so loads still see it this cycle.
  always_comb begin
    validMask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      validMask[i] = ({1'b0, PtrW'(i) - head} < count);
    end
  end

  stbuf_match #(.DEPTH(DEPTH)) u_fwd_match (
    .entries    (entries),
    .validMask  (validMask),
    .tail       (tail),
    .lookupAddr (wordAddr),
    .hit        (fwdHit),
    .hit_data   (fwdData)
  );

  assign ReadDataM = fwdHit ? fwdData : mem_rdata;

`ifdef STBUF_COALESCE_EN
  logic [DEPTH-1:0] tailMask;
  logic             coalHit;
  logic [31:0]      coalData;

  always_comb begin
    tailMask = '0;
    if (!empty) tailMask[tailLast] = 1'b1;
  end

  stbuf_match #(.DEPTH(DEPTH)) u_coal_match (
    .entries    (entries),
    .validMask  (tailMask),
    .tail       (tail),
    .lookupAddr (wordAddr),
    .hit        (coalHit),
    .hit_data   (coalData)
  );

  // The tail-most entry is also the head when count is 1; never rewrite it while it drains.
  assign coalesce = MemWriteM && coalHit && !(pop && (count == CntW'(1)));
`else
  assign coalesce = 1'b0;
`endif

  assign push = MemWriteM && !coalesce && (!full || pop);
  assign drop = MemWriteM && !coalesce && full && !pop;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) tail <= tail + PtrW'(1);
      if (pop)  head <= head + PtrW'(1);
      if (push && !pop)      count <= count + CntW'(1);
      else if (pop && !push) count <= count - CntW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // NOTE: the entry array has no reset; count gates validity, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{addr: wordAddr, data: WriteDataM};
    end
`ifdef STBUF_COALESCE_EN
    else if (coalesce) begin
      entries[tailLast].data <= WriteDataM;
    end
`endif
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: a queue model of the buffer predicts
// drains, occupancy, flags and forwarded load data every cycle.
module tb_dmem_store_buffer;
  import stbuf_pkg::*;

  localparam int DEPTH = 4;

  logic        clk, reset, MemWriteM, mem_wready;
  logic [31:0] ALUResultM, WriteDataM, ReadDataM, mem_raddr, mem_rdata;
  logic        mem_we, full, empty, overflow;
  logic [31:0] mem_waddr, mem_wdata;
  logic [2:0]  count;

  int           nChecks = 0;
  int           nFails  = 0;
  stbuf_entry_t sbq[$];
  logic         expOvf = 1'b0;

  dmem_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .ReadDataM  (ReadDataM),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wready (mem_wready),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model step: compare pre-edge outputs, then apply the edge's push/pop/drop.
  task automatic scoreStep();
    int           sz;
    logic         popNow, coal;
    logic [31:0]  fwd;
    stbuf_entry_t item;
    sz = sbq.size();
    check("count",    32'(count),    32'(sz));
    check("mem_we",   32'(mem_we),   32'(sz != 0));
    check("full",     32'(full),     32'(sz == DEPTH));
    check("empty",    32'(empty),    32'(sz == 0));
    check("overflow", 32'(overflow), 32'(expOvf));
    check("mem_raddr", mem_raddr, ALUResultM);
    fwd = mem_rdata;
    foreach (sbq[i]) if (sbq[i].addr == ALUResultM[31:2]) fwd = sbq[i].data;
    check("ReadDataM", ReadDataM, fwd);
    popNow = (sz != 0) && mem_wready;
    coal   = 1'b0;
`ifdef STBUF_COALESCE_EN
    if (MemWriteM && sz != 0 && sbq[sz-1].addr == ALUResultM[31:2] && !(popNow && sz == 1))
      coal = 1'b1;
`endif
    if (popNow) begin
      item = sbq.pop_front();
      check("drain_addr", mem_waddr, {item.addr, 2'b00});
      check("drain_data", mem_wdata, item.data);
    end
    if (coal) sbq[$].data = WriteDataM;
    else if (MemWriteM) begin
      if (sz < DEPTH || popNow) sbq.push_back('{addr: ALUResultM[31:2], data: WriteDataM});
      else expOvf = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      sbq.delete();
      expOvf = 1'b0;
    end else begin
      scoreStep();
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    MemWriteM  = 1'b1;
    ALUResultM = addr;
    WriteDataM = data;
    cycle();
    MemWriteM  = 1'b0;
  endtask

  task automatic doReset();
    reset      = 1'b0;
    MemWriteM  = 1'b0;
    mem_wready = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; MemWriteM = 1'b0; mem_wready = 1'b0;
    ALUResultM = 32'h0; WriteDataM = 32'h0; mem_rdata = 32'hDEAD_BEEF;
    cycle();
    cycle();
    check("rst_empty",    32'(empty),    32'd1);
    check("rst_full",     32'(full),     32'd0);
    check("rst_mem_we",   32'(mem_we),   32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_rdata",    ReadDataM,     32'hDEAD_BEEF);
    reset = 1'b1;
    cycle();

    // Basic store then load; neighbouring word falls through to memory.
    store(32'h100, 32'h1111_1111);
    ALUResultM = 32'h100; mem_rdata = 32'hCAFE_F00D; #1;
    check("fwd_hit", ReadDataM, 32'h1111_1111);
    ALUResultM = 32'h104; #1;
    check("fwd_miss", ReadDataM, 32'hCAFE_F00D);

    // Same word through different byte offsets: youngest wins.
    doReset();
    store(32'h200, 32'h0000_000A);
    store(32'h203, 32'h0000_000B);
`ifdef STBUF_COALESCE_EN
    check("young_count", 32'(count), 32'd1);
`else
    check("young_count", 32'(count), 32'd2);
`endif
    ALUResultM = 32'h200; #1;
    check("young_data", ReadDataM, 32'h0000_000B);

    // Fill, drop a store, then push and pop together at full.
    doReset();
    for (int i = 0; i < DEPTH; i++) store(32'h400 + 32'(4 * i), 32'h4000 + 32'(i));
    check("fill_full",  32'(full),  32'd1);
    check("fill_count", 32'(count), 32'd4);
    store(32'h500, 32'h5555_5555);
    check("drop_ovf",   32'(overflow), 32'd1);
    check("drop_count", 32'(count),    32'd4);
    ALUResultM = 32'h500; mem_rdata = 32'h1357_9BDF; #1;
    check("drop_not_fwd", ReadDataM, 32'h1357_9BDF);
    mem_wready = 1'b1;
    store(32'h504, 32'h5050_5050);
    mem_wready = 1'b0; #1;
    check("pushpop_count", 32'(count),    32'd4);
    check("pushpop_head",  mem_waddr,     32'h404);
    check("pushpop_ovf",   32'(overflow), 32'd1);

    // Ordered drain with a stall in the middle.
    doReset();
    store(32'h600, 32'h6000_0000);
    store(32'h604, 32'h6000_0004);
    store(32'h608, 32'h6000_0008);
    check("drain_head0", mem_waddr, 32'h600);
    mem_wready = 1'b1; cycle();
    check("drain_head1", mem_waddr, 32'h604);
    mem_wready = 1'b0; cycle();
    check("stall_we",   32'(mem_we), 32'd1);
    check("stall_addr", mem_waddr,   32'h604);
    check("stall_data", mem_wdata,   32'h6000_0004);
    mem_wready = 1'b1; cycle();
    check("drain_head2", mem_waddr, 32'h608);
    cycle();
    mem_wready = 1'b0; #1;
    check("drain_empty", 32'(empty), 32'd1);

    // Reset in the middle of a drain, with overflow set beforehand.
    doReset();
    for (int i = 0; i < DEPTH + 1; i++) store(32'h800 + 32'(4 * i), 32'h8000 + 32'(i));
    mem_wready = 1'b1;
    cycle();
    cycle();
    check("mid_count", 32'(count), 32'd2);
    reset = 1'b0;
    cycle();
    check("mid_rst_we",    32'(mem_we),   32'd0);
    check("mid_rst_count", 32'(count),    32'd0);
    check("mid_rst_ovf",   32'(overflow), 32'd0);
    reset = 1'b1; mem_wready = 1'b0;
    cycle();

    // Two stores to one word while the port is stalled.
    doReset();
    store(32'h300, 32'h1234_0001);
    store(32'h300, 32'h1234_0002);
`ifdef STBUF_COALESCE_EN
    check("coal_count", 32'(count), 32'd1);
    check("coal_wdata", mem_wdata,  32'h1234_0002);
`else
    check("coal_count", 32'(count), 32'd2);
    check("coal_wdata", mem_wdata,  32'h1234_0001);
`endif

    // Back-to-back streaming: one push and one pop every cycle.
    doReset();
    mem_wready = 1'b1;
    for (int i = 0; i < 6; i++) store(32'h700 + 32'(4 * i), 32'h7000 + 32'(i));
    check("stream_count", 32'(count), 32'd1);

    for (int i = 0; i < 20 && !empty; i++) cycle();
    check("final_empty", 32'(empty), 32'd1);
    mem_wready = 1'b0;
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
